// File: rtl/bowling.sv
// rtl/bowling.sv - ten-pin bowling score calculator with roll store and 10-cycle frame walker
module bowling (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  input  logic [3:0] pin_count,
  input  logic       calculate_score,
  output logic [8:0] score
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  rolls [0:20];
  logic [4:0]  roll_idx;
  logic [3:0]  frame_cnt;
  logic [4:0]  frame_ptr;
  logic [8:0]  acc;

  logic [3:0]  r0, r1, r2;
  logic [4:0]  frame_sum;
  logic [4:0]  ptr_adv;
  logic [4:0]  pair_sum;
  logic [3:0]  pins_clamped;

  // Reads beyond the last stored entry behave as zero pins
  function automatic logic [3:0] roll_at(input logic [5:0] i);
    if (i <= 6'd20)
      return rolls[i[4:0]];
    else
      return 4'd0;
  endfunction

  always_comb begin
    r0 = roll_at({1'b0, frame_ptr});
    r1 = roll_at({1'b0, frame_ptr} + 6'd1);
    r2 = roll_at({1'b0, frame_ptr} + 6'd2);
  end

  always_comb begin
    pair_sum = {1'b0, r0} + {1'b0, r1};
    frame_sum = pair_sum;
    ptr_adv = 5'd2;
    if (r0 == 4'd10) begin
      frame_sum = 5'd10 + {1'b0, r1} + {1'b0, r2};
      ptr_adv = 5'd1;
    end else if (pair_sum == 5'd10) begin
      frame_sum = 5'd10 + {1'b0, r2};
    end
  end

  assign pins_clamped = (pin_count > 4'd10) ? 4'd10 : pin_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (calculate_score) state_next = CALC;
      CALC:    if (frame_cnt == 4'd9) state_next = DONE;
      DONE:    if (!calculate_score) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // frame_ptr and frame_cnt return to zero at the final load so IDLE always scores from frame 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 21; i++)
        rolls[i] <= 4'd0;
      roll_idx  <= 5'd0;
      frame_cnt <= 4'd0;
      frame_ptr <= 5'd0;
      acc       <= 9'd0;
      score     <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (calculate_score) begin
            acc       <= {4'd0, frame_sum};
            frame_ptr <= frame_ptr + ptr_adv;
            frame_cnt <= 4'd1;
          end else if (roll && roll_idx < 5'd21) begin
            rolls[roll_idx] <= pins_clamped;
            roll_idx        <= roll_idx + 5'd1;
          end
        end
        CALC: begin
          if (frame_cnt == 4'd9) begin
            score     <= acc + {4'd0, frame_sum};
            acc       <= 9'd0;
            frame_ptr <= 5'd0;
            frame_cnt <= 4'd0;
          end else begin
            acc       <= acc + {4'd0, frame_sum};
            frame_ptr <= frame_ptr + ptr_adv;
            frame_cnt <= frame_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bowling.sv
// tb/tb_bowling.sv - directed scoreboard bench for the bowling score calculator
module tb_bowling;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       roll = 1'b0;
  logic [3:0] pin_count = 4'd0;
  logic       calculate_score = 1'b0;
  logic [8:0] score;

  int n_err = 0;
  int n_chk = 0;
  int sb[$];
  int last_score = 0;

  bowling dut (
    .clock(clock),
    .reset(reset),
    .roll(roll),
    .pin_count(pin_count),
    .calculate_score(calculate_score),
    .score(score)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    roll = 1'b0;
    calculate_score = 1'b0;
    #1 check("score_in_reset", score, 9'd0);
    last_score = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic do_roll(input int pins);
    @(negedge clock);
    roll = 1'b1;
    pin_count = pins[3:0];
    @(negedge clock);
    roll = 1'b0;
  endtask

  task automatic roll_n(input int n, input int pins);
    for (int i = 0; i < n; i++)
      do_roll(pins);
  endtask

  // Raise the request, confirm the old score holds after 9 edges, then compare on the 10th
  task automatic do_calc(input string tag, input int expected);
    int got;
    sb.push_back(expected);
    @(negedge clock);
    calculate_score = 1'b1;
    repeat (9) @(negedge clock);
    check({tag, "_hold"}, score, last_score[8:0]);
    @(negedge clock);
    got = sb.pop_front();
    check(tag, score, got[8:0]);
    last_score = got;
  endtask

  task automatic drop_calc();
    @(negedge clock);
    calculate_score = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    do_reset();

    do_roll(8);
    roll_n(19, 0);
    do_calc("single_8", 8);
    drop_calc();

    do_reset();
    roll_n(3, 5);
    roll_n(17, 0);
    do_calc("spare", 20);
    drop_calc();

    do_reset();
    do_roll(10);
    do_roll(3);
    do_roll(4);
    roll_n(16, 0);
    do_calc("strike", 24);
    do_roll(10);
    drop_calc();
    do_calc("strike_roll_in_done", 24);
    drop_calc();

    do_reset();
    roll_n(12, 10);
    do_calc("perfect", 300);
    repeat (5) @(negedge clock);
    check("perfect_held", score, 9'd300);
    drop_calc();
    check("perfect_idle", score, 9'd300);
    do_calc("perfect_again", 300);
    drop_calc();

    do_reset();
    roll_n(22, 5);
    do_calc("all_fives_22nd_ignored", 150);
    drop_calc();

    do_reset();
    do_roll(15);
    do_roll(3);
    do_roll(4);
    roll_n(17, 0);
    do_calc("clamp_15", 24);
    drop_calc();

    // Abort a calculation by reset after a known nonzero score
    do_reset();
    roll_n(12, 10);
    do_calc("pre_abort", 300);
    drop_calc();
    @(negedge clock);
    calculate_score = 1'b1;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    calculate_score = 1'b0;
    #1 check("abort_reset", score, 9'd0);
    last_score = 0;
    @(negedge clock);
    reset = 1'b1;
    roll_n(20, 1);
    do_calc("after_abort_ones", 20);
    drop_calc();

    check("scoreboard_empty", 9'(sb.size()), 9'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
